// File: rtl/iiitb_rtc_pkg.sv
// Shared types, field codes and BCD helpers for the RTC time-setting controller.
package iiitb_rtc_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } rtc_state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [6:0] HR_MAX = 7'd23;
    localparam logic [6:0] MS_MAX = 7'd59;

    typedef struct packed {
        logic [3:0] hrm;
        logic [3:0] hrl;
        logic [3:0] minm;
        logic [3:0] minl;
        logic [3:0] secm;
        logic [3:0] secl;
    } bcd_time_t;

    // One step up or down of a two-digit BCD field that wraps at max_val.
    // Out-of-range captured values snap to 00 on inc and to max_val on dec,
    // so the result is always a valid in-range BCD pair.
    function automatic logic [7:0] bcd_step(input logic [3:0] tens,
                                            input logic [3:0] units,
                                            input logic       up,
                                            input logic [6:0] max_val);
        logic [7:0] val;
        logic [7:0] nxt;
        val = 8'(tens) * 8'd10 + 8'(units);
        if (up)
            nxt = (val >= {1'b0, max_val}) ? 8'd0 : val + 8'd1;
        else
            nxt = (val == 8'd0 || val > {1'b0, max_val}) ? {1'b0, max_val} : val - 8'd1;
        return {4'(nxt / 8'd10), 4'(nxt % 8'd10)};
    endfunction

endpackage

// File: rtl/iiitb_rtc_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, level debouncer, rising-edge press pulse.
module iiitb_rtc_btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Flip the debounced level after DEB_CYCLES consecutive differing samples;
    // the press pulse is registered alongside the 0->1 flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_b;
                    cnt   <= '0;
                    press <= sync_b;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/iiitb_rtc_set_ctrl.sv
// Time-setting controller: edits hours/minutes/seconds in shadow registers while
// the RTC is halted, then strobes load for one cycle.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | clock running, buttons other than mode ignored
// ST_SET_HR  | halted, inc/dec adjust hours (00..23)
// ST_SET_MIN | halted, inc/dec adjust minutes (00..59)
// ST_SET_SEC | halted, inc/dec adjust seconds (00..59)
// ST_COMMIT  | one cycle: load strobe with shadow digits, then back to run
module iiitb_rtc_set_ctrl
    import iiitb_rtc_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] cur_hrm,
    input  logic [3:0] cur_hrl,
    input  logic [3:0] cur_minm,
    input  logic [3:0] cur_minl,
    input  logic [3:0] cur_secm,
    input  logic [3:0] cur_secl,
    output logic       halt,
    output logic       load,
    output logic [3:0] ld_hrm,
    output logic [3:0] ld_hrl,
    output logic [3:0] ld_minm,
    output logic [3:0] ld_minl,
    output logic [3:0] ld_secm,
    output logic [3:0] ld_secl,
    output logic [1:0] field
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic mode_p, inc_p, dec_p;
    logic any_p, adj, adj_up;

    rtc_state_t        state, state_n;
    bcd_time_t         shadow, shadow_n, cur_time;
    logic [IDLE_W-1:0] idle, idle_n;

    iiitb_rtc_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .btn(btn_mode), .press(mode_p));
    iiitb_rtc_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .btn(btn_inc), .press(inc_p));
    iiitb_rtc_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk(clk), .rst(rst), .btn(btn_dec), .press(dec_p));

    assign cur_time = {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl};
    assign any_p    = mode_p | inc_p | dec_p;
    assign adj      = ~mode_p & (inc_p ^ dec_p);
    assign adj_up   = inc_p;

    assign ld_hrm  = shadow.hrm;
    assign ld_hrl  = shadow.hrl;
    assign ld_minm = shadow.minm;
    assign ld_minl = shadow.minl;
    assign ld_secm = shadow.secm;
    assign ld_secl = shadow.secl;

    // State, shadow time and idle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            shadow <= '0;
            idle   <= '0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            idle   <= idle_n;
        end
    end

    // Next-state, field editing, timeout and state-decoded outputs.
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        idle_n   = idle;
        halt     = 1'b0;
        load     = 1'b0;
        field    = FIELD_NONE;
        case (state)
            ST_RUN: begin
                idle_n = '0;
                if (mode_p) begin
                    state_n  = ST_SET_HR;
                    shadow_n = cur_time;
                end
            end
            ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
                halt = 1'b1;
                if (any_p) begin
                    idle_n = '0;
                end else if (idle == IDLE_LAST) begin
                    idle_n  = '0;
                    state_n = ST_RUN;
                end else begin
                    idle_n = idle + 1'b1;
                end
                case (state)
                    ST_SET_HR: begin
                        field = FIELD_HR;
                        if (mode_p)
                            state_n = ST_SET_MIN;
                        else if (adj)
                            {shadow_n.hrm, shadow_n.hrl} =
                                bcd_step(shadow.hrm, shadow.hrl, adj_up, HR_MAX);
                    end
                    ST_SET_MIN: begin
                        field = FIELD_MIN;
                        if (mode_p)
                            state_n = ST_SET_SEC;
                        else if (adj)
                            {shadow_n.minm, shadow_n.minl} =
                                bcd_step(shadow.minm, shadow.minl, adj_up, MS_MAX);
                    end
                    default: begin
                        field = FIELD_SEC;
                        if (mode_p)
                            state_n = ST_COMMIT;
                        else if (adj)
                            {shadow_n.secm, shadow_n.secl} =
                                bcd_step(shadow.secm, shadow.secl, adj_up, MS_MAX);
                    end
                endcase
            end
            ST_COMMIT: begin
                halt    = 1'b1;
                load    = 1'b1;
                idle_n  = '0;
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_iiitb_rtc_set_ctrl.sv
// Directed and randomized bench for the RTC time-setting controller.
module tb_iiitb_rtc_set_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_inc, btn_dec;
    logic [3:0] cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl;
    logic       halt, load;
    logic [3:0] ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl;
    logic [1:0] field;

    iiitb_rtc_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hrm(cur_hrm), .cur_hrl(cur_hrl), .cur_minm(cur_minm),
        .cur_minl(cur_minl), .cur_secm(cur_secm), .cur_secl(cur_secl),
        .halt(halt), .load(load),
        .ld_hrm(ld_hrm), .ld_hrl(ld_hrl), .ld_minm(ld_minm),
        .ld_minl(ld_minl), .ld_secm(ld_secm), .ld_secl(ld_secl),
        .field(field));

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int load_cnt = 0;
    logic [23:0] last_load_val = '0;

    // Reference model: field being edited (0 none) and time as plain integers.
    int ref_field = 0;
    int ref_h = 0, ref_m = 0, ref_s = 0;
    int cur_h = 0, cur_m = 0, cur_s = 0;

    wire [23:0] ld_word = {ld_hrm, ld_hrl, ld_minm, ld_minl, ld_secm, ld_secl};

    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_cnt++;
            last_load_val = ld_word;
        end
    end

    function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int wrap_step(input int v, input int maxv, input bit up);
        if (up) return (v >= maxv) ? 0 : v + 1;
        return (v == 0) ? maxv : v - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        logic [23:0] w;
        cur_h = h; cur_m = m; cur_s = s;
        w = to_bcd(h, m, s);
        {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl} = w;
    endtask

    // Hold the chosen buttons for 10 cycles, checking the cycle-exact effect of
    // the press pulse (edge 6) on the following edge 7, then release.
    task automatic press(input logic m, input logic i, input logic d);
        int old_field;
        bit commit;
        old_field = ref_field;
        commit = 0;
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (6) @(negedge clk);
        check("pre_field", 32'(field), 32'(old_field));
        check("pre_halt", 32'(halt), 32'(old_field != 0));
        if (m) begin
            if (ref_field == 0) begin
                ref_field = 1; ref_h = cur_h; ref_m = cur_m; ref_s = cur_s;
            end else if (ref_field == 3) begin
                commit = 1; ref_field = 0;
            end else begin
                ref_field++;
            end
        end else if (i != d && ref_field != 0) begin
            case (ref_field)
                1: ref_h = wrap_step(ref_h, 23, i);
                2: ref_m = wrap_step(ref_m, 59, i);
                default: ref_s = wrap_step(ref_s, 59, i);
            endcase
        end
        @(negedge clk);
        if (commit) begin
            check("commit_load", 32'(load), 32'd1);
            check("commit_halt", 32'(halt), 32'd1);
            check("commit_value", 32'(ld_word), 32'(to_bcd(ref_h, ref_m, ref_s)));
        end else begin
            check("field", 32'(field), 32'(ref_field));
            check("halt", 32'(halt), 32'(ref_field != 0));
            check("load_idle", 32'(load), 32'd0);
            if (ref_field != 0)
                check("shadow", 32'(ld_word), 32'(to_bcd(ref_h, ref_m, ref_s)));
        end
        @(negedge clk);
        check("load_after", 32'(load), 32'd0);
        check("halt_after", 32'(halt), 32'(ref_field != 0));
        check("field_after", 32'(field), 32'(ref_field));
        repeat (2) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int lc;
        int n;
        int r;
        rst = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        set_cur(0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_field", 32'(field), 32'd0);
        check("rst_ld", 32'(ld_word), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Capture 12:34:56 and edit hours across the 23/00 wrap.
        set_cur(12, 34, 56);
        press(1, 0, 0);
        check("capture", 32'(ld_word), 32'h123456);
        set_cur(23, 10, 20);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        check("hr_wrap_up", 32'({ld_hrm, ld_hrl}), 32'h00);
        press(0, 0, 1);
        press(0, 0, 1);
        check("hr_wrap_dn", 32'({ld_hrm, ld_hrl}), 32'h22);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);

        // Edit 10:58:01 into 09:59:00 and commit.
        set_cur(10, 58, 1);
        press(1, 0, 0); press(0, 0, 1);
        press(1, 0, 0); press(0, 1, 0);
        press(1, 0, 0); press(0, 0, 1);
        lc = load_cnt;
        press(1, 0, 0);
        check("load_once", 32'(load_cnt - lc), 32'd1);
        check("load_095900", 32'(last_load_val), 32'h095900);

        // Out-of-range captured hour goes to 00 on first inc.
        set_cur(25, 0, 0);
        press(1, 0, 0); press(0, 1, 0);
        check("hr25_inc", 32'({ld_hrm, ld_hrl}), 32'h00);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);

        // Timeout from SET_MIN without load.
        set_cur(7, 8, 9);
        press(1, 0, 0); press(1, 0, 0);
        lc = load_cnt;
        repeat (150) @(negedge clk);
        check("tmo_still_min", 32'(field), 32'd2);
        repeat (60) @(negedge clk);
        ref_field = 0;
        check("tmo_halt", 32'(halt), 32'd0);
        check("tmo_field", 32'(field), 32'd0);
        check("tmo_no_load", 32'(load_cnt - lc), 32'd0);

        // Randomized edit sessions against the model.
        for (int it = 0; it < 6; it++) begin
            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    int'($urandom_range(0, 59)));
            press(1, 0, 0);
            for (int f = 0; f < 3; f++) begin
                n = int'($urandom_range(0, 4));
                for (int k = 0; k < n; k++) begin
                    r = int'($urandom_range(0, 2));
                    press(1'b0, r != 1, r != 0);
                end
                press(1, 0, 0);
            end
        end

        // Glitch, simultaneous presses, then reset mid-edit.
        set_cur(4, 5, 6);
        press(1, 0, 0);
        @(negedge clk); btn_inc = 1'b1;
        repeat (3) @(negedge clk); btn_inc = 1'b0;
        repeat (15) @(negedge clk);
        check("glitch_ld", 32'(ld_word), 32'h040506);
        check("glitch_field", 32'(field), 32'd1);
        press(1, 0, 0); press(1, 0, 0);
        press(0, 1, 1);
        check("incdec_ignored", 32'(ld_word), 32'h040506);
        lc = load_cnt;
        press(1, 1, 0);
        check("mode_inc_commit", 32'(last_load_val), 32'h040506);
        check("mode_inc_load", 32'(load_cnt - lc), 32'd1);

        set_cur(11, 22, 33);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        lc = load_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_field = 0;
        check("rst_mid_halt", 32'(halt), 32'd0);
        check("rst_mid_load", 32'(load), 32'd0);
        check("rst_mid_field", 32'(field), 32'd0);
        check("rst_mid_ld", 32'(ld_word), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_load", 32'(load_cnt - lc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/iiitb_rtc_set_ctrl.md
# iiitb_rtc_set_ctrl

Time-setting controller for the BCD real-time clock. Takes three push-buttons (mode, inc, dec) and sequences an edit of hours, minutes and seconds in shadow registers while the clock is halted. On completion it issues a single-cycle load of the new BCD time into the RTC counters. It sits between board buttons and the RTC counter chain and owns the RTC's halt and load controls.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required before a button level change is accepted.
- `TIMEOUT_CYCLES`, default 1000000: idle cycles in an edit state before the edit is abandoned.
- `clk` in 1: single system clock.
- `rst` in 1: reset; synchronous and active-high.
- `btn_mode`, `btn_inc`, `btn_dec` in 1 each: raw asynchronous buttons, active-high.
- `cur_hrm`, `cur_hrl`, `cur_minm`, `cur_minl`, `cur_secm`, `cur_secl` in 4 each: live RTC BCD digits.
- `halt` out 1: high while editing; the RTC must hold its count.
- `load` out 1: one-cycle strobe; the RTC takes the `ld_*` digits.
- `ld_hrm`, `ld_hrl`, `ld_minm`, `ld_minl`, `ld_secm`, `ld_secl` out 4 each: shadow BCD digits, valid whenever `halt` or `load` is high.
- `field` out 2: field being edited (0 none, 1 hours, 2 minutes, 3 seconds), for display blink.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debounced level flips after `DEB_CYCLES` consecutive synchronized samples that differ from it.
  - A press pulse (1 cycle) is generated on the debounced 0→1 edge only.
- States and transitions:
  - RUN → SET_HR on a mode press. Capture `cur_*` into the shadow registers.
  - SET_HR → SET_MIN on a mode press.
  - SET_MIN → SET_SEC on a mode press.
  - SET_SEC → COMMIT on a mode press.
  - COMMIT → RUN unconditionally.
- Outputs by state:
  - RUN: `halt`=0, `field`=0.
  - SET_HR, SET_MIN, SET_SEC: `halt`=1, `field`=1, 2, 3 respectively.
  - COMMIT: `load`=1 and `halt`=1.
- Inc/dec in a SET state adjusts the two-digit BCD field with wrap:
  - Hours: 00..23; 23+1→00, 00−1→23.
  - Minutes and seconds: 00..59; 59+1→00, 00−1→59.
  - Units digit carries and borrows into the tens digit; the result is always valid BCD.
- Simultaneous press pulses in one cycle:
  - Mode present: mode acts; inc and dec are ignored.
  - Inc and dec together without mode: both ignored.
- Press pulses for inc or dec in RUN or COMMIT are ignored.
- Timeout:
  - Idle counter clears on any press pulse and on entry to SET_HR.
  - It increments every cycle in a SET state.
  - Reaching `TIMEOUT_CYCLES`−1 returns to RUN with no `load`; the RTC resumes from its held value.
- Captured values are not range-checked. An out-of-range hour such as 25 is carried as-is until first edited; the first inc then yields 00.

## Timing
- Reset values:
  - State RUN; `halt`, `load`, `field` = 0.
  - All `ld_*` = 0; debounced levels = 0; debounce and idle counters = 0.
- Press latency: with a raw button held high, the press pulse asserts on the (2+`DEB_CYCLES`)th rising edge after the first edge that samples it high.
- The FSM acts in the cycle the pulse is high. State, `field`, shadow and `halt` changes are registered and visible on the next cycle.
- `load` is high for exactly one cycle, the cycle after the committing mode pulse. `halt` falls the cycle after `load`.
- `halt` rises one cycle after the RUN mode pulse. Capture uses `cur_*` sampled in the pulse cycle.
- `rst` mid-edit: next cycle is RUN with no `load`, and reset values apply.

## Structure
- Package `iiitb_rtc_pkg` holds:
  - the state enum (RUN, SET_HR, SET_MIN, SET_SEC, COMMIT);
  - field codes;
  - BCD limits (HR_MAX=23, MS_MAX=59).
- Sub-module `iiitb_rtc_btn_debounce` (synchronizer, debouncer and edge pulse, parameter `DEB_CYCLES`) is instantiated three times.
- The BCD inc/dec wrap logic is a package function parameterised by the field maximum.

## Test plan
- Reset, then `cur`=12:34:56, hold mode for 10 cycles (`DEB_CYCLES`=4):
  - Press pulse is on edge 6.
  - `halt`=1, `field`=1, `ld`=12:34:56.
- In SET_HR with `ld`=23:xx:xx, press inc, then press dec twice:
  - After inc the hours read 00.
  - After the two decs the hours read 22.
- Edit to 09:59:00 and press mode three times:
  - `load` is high for one cycle carrying 09:59:00.
  - `halt` drops the next cycle; `field`=0.
- Enter SET_MIN and apply no presses for `TIMEOUT_CYCLES` cycles:
  - Returns to RUN with `load` never asserted.
- Assert inc and dec together in SET_SEC, then mode and inc together:
  - Shadow values are unchanged.
  - Mode advances to COMMIT.
- Glitch inc high for 3 cycles only: no pulse and no change. Assert `rst` in SET_SEC: RUN next cycle, all outputs 0.
